// File: rtl/int_to_float_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : int_to_float_pipe_if
// Purpose  : Handshake bundle between an integer producer, the converter and
//            a floating-point consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface int_to_float_pipe_if #(
  parameter int INT_WIDTH = 16,
  parameter int MAN_WIDTH = 8,
  parameter int EXP_WIDTH = 5
);
  logic                               in_valid_i;
  logic                               in_ready_o;
  logic [INT_WIDTH-1:0]               int_i;
  logic                               out_valid_o;
  logic                               out_ready_i;
  logic [EXP_WIDTH+MAN_WIDTH:0]       float_o;

  // Converter side
  modport slave (
    input  in_valid_i, int_i, out_ready_i,
    output in_ready_o, out_valid_o, float_o
  );

  // Producer/consumer side
  modport master (
    output in_valid_i, int_i, out_ready_i,
    input  in_ready_o, out_valid_o, float_o
  );
endinterface
`default_nettype wire

// File: rtl/int_to_float_pipe.sv
`default_nettype none
// ============================================================================
// Module   : int_to_float_pipe
// Purpose  : Handshaked signed-integer to {sign, exp, mant} converter with an
//            iterative one-bit-per-cycle normaliser. Value = 0.mant * 2^exp.
//            Optional macro INT_TO_FLOAT_ROUND_EN: round-to-nearest-even on
//            the dropped bits (default: truncate).
// Revision : 1.0 - initial release
// ============================================================================
module int_to_float_pipe #(
  parameter int INT_WIDTH = 16,
  parameter int MAN_WIDTH = 8,
  parameter int EXP_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  int_to_float_pipe_if.slave   bus
);

  localparam int FLOAT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam logic [EXP_WIDTH-1:0] EXP_INIT = EXP_WIDTH'(INT_WIDTH);
  localparam logic [EXP_WIDTH-1:0] EXP_ONE  = EXP_WIDTH'(1);
  localparam logic [INT_WIDTH-1:0] MAG_ONE  = INT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic [INT_WIDTH-1:0]   mag_q, mag_d;
  logic [EXP_WIDTH-1:0]   exp_q, exp_d;
  logic [FLOAT_WIDTH-1:0] float_q, float_d;

  logic [INT_WIDTH-1:0]   abs_in;
  logic [MAN_WIDTH-1:0]   mant_trunc;
  logic [MAN_WIDTH-1:0]   mant_final;
  logic [EXP_WIDTH-1:0]   exp_final;

  // The most negative input wraps to 2^(INT_WIDTH-1), which is exactly its magnitude.
  assign abs_in = bus.int_i[INT_WIDTH-1] ? (~bus.int_i + MAG_ONE) : bus.int_i;

  generate
    if (INT_WIDTH >= MAN_WIDTH) begin : g_mant_wide
      assign mant_trunc = mag_q[INT_WIDTH-1 -: MAN_WIDTH];
    end else begin : g_mant_narrow
      assign mant_trunc = {mag_q, {(MAN_WIDTH-INT_WIDTH){1'b0}}};
    end
  endgenerate

`ifdef INT_TO_FLOAT_ROUND_EN
  localparam logic [MAN_WIDTH-1:0] MANT_MSB = MAN_WIDTH'(1) << (MAN_WIDTH-1);

  logic               round_guard;
  logic               round_sticky;
  logic               round_up;
  logic [MAN_WIDTH:0] mant_sum;

  generate
    if (INT_WIDTH > MAN_WIDTH + 1) begin : g_rnd_multi
      assign round_guard  = mag_q[INT_WIDTH-MAN_WIDTH-1];
      assign round_sticky = |mag_q[INT_WIDTH-MAN_WIDTH-2:0];
    end else if (INT_WIDTH == MAN_WIDTH + 1) begin : g_rnd_single
      assign round_guard  = mag_q[0];
      assign round_sticky = 1'b0;
    end else begin : g_rnd_none
      assign round_guard  = 1'b0;
      assign round_sticky = 1'b0;
    end
  endgenerate

  assign round_up = round_guard & (round_sticky | mant_trunc[0]);
  assign mant_sum = {1'b0, mant_trunc} + {{MAN_WIDTH{1'b0}}, round_up};
  // Carry out of the mantissa renormalises to 0.100..0 one binade up.
  assign mant_final = mant_sum[MAN_WIDTH] ? MANT_MSB : mant_sum[MAN_WIDTH-1:0];
  assign exp_final  = mant_sum[MAN_WIDTH] ? (exp_q + EXP_ONE) : exp_q;
`else
  assign mant_final = mant_trunc;
  assign exp_final  = exp_q;
`endif

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    float_d = float_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid_i) begin
          sign_d = bus.int_i[INT_WIDTH-1];
          mag_d  = abs_in;
          exp_d  = EXP_INIT;
          if (abs_in == '0) begin
            float_d = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (mag_q[INT_WIDTH-1]) begin
          float_d = {sign_q, exp_final, mant_final};
          state_d = ST_DONE;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_ONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      float_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      float_q <= float_d;
    end
  end

  assign bus.in_ready_o  = (state_q == ST_IDLE);
  assign bus.out_valid_o = (state_q == ST_DONE);
  assign bus.float_o     = float_q;

endmodule
`default_nettype wire

// File: tb/tb_int_to_float_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_to_float_pipe
// Purpose  : Self-checking bench for int_to_float_pipe against an arithmetic
//            reference model (honours INT_TO_FLOAT_ROUND_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_to_float_pipe;

  localparam int IW = 16;
  localparam int MW = 8;
  localparam int EW = 5;
  localparam int FW = 1 + EW + MW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  int_to_float_pipe_if #(.INT_WIDTH(IW), .MAN_WIDTH(MW), .EXP_WIDTH(EW)) bus ();

  int_to_float_pipe #(.INT_WIDTH(IW), .MAN_WIDTH(MW), .EXP_WIDTH(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Value = 0.mant * 2^exp, mantissa taken from the real magnitude.
  function automatic logic [FW-1:0] model(input logic [IW-1:0] v);
    longint s, mag, mant, rem, half;
    int     e, sh;
    logic   sgn;
    s   = longint'($signed(v));
    sgn = (s < 0);
    mag = sgn ? -s : s;
    if (mag == 0) return '0;
    e = 0;
    while ((64'sd1 <<< e) <= mag) e++;
    if (e > MW) begin
      sh   = e - MW;
      mant = mag >>> sh;
      rem  = mag - (mant <<< sh);
      half = 64'sd1 <<< (sh - 1);
`ifdef INT_TO_FLOAT_ROUND_EN
      if (rem > half || (rem == half && (mant % 2) == 1)) mant++;
      if (mant == (64'sd1 <<< MW)) begin
        mant = 64'sd1 <<< (MW - 1);
        e++;
      end
`else
      if (rem < 0 || half < 0) mant = 0;
`endif
    end else begin
      mant = mag <<< (MW - e);
    end
    return {sgn, EW'(e), MW'(mant)};
  endfunction

  function automatic int latency(input logic [IW-1:0] v);
    longint s, mag;
    int     e;
    s   = longint'($signed(v));
    mag = (s < 0) ? -s : s;
    if (mag == 0) return 0;
    e = 0;
    while ((64'sd1 <<< e) <= mag) e++;
    return (IW - e) + 1;
  endfunction

  // Called on a negedge with the DUT idle; returns on a negedge with it idle again.
  task automatic convert(input logic [IW-1:0] v, input int stall);
    int             cyc;
    logic [FW-1:0]  held;
    check("in_ready_idle", 32'(bus.in_ready_o), 32'd1);
    bus.in_valid_i  = 1'b1;
    bus.int_i       = v;
    bus.out_ready_i = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.int_i      = IW'($urandom);
    cyc = 0;
    while (!bus.out_valid_o && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(latency(v)));
    check("float", 32'(bus.float_o), 32'(model(v)));
    held = bus.float_o;
    for (int i = 0; i < stall; i++) begin
      bus.in_valid_i = 1'b1;
      bus.int_i      = IW'($urandom);
      @(negedge clk);
      check("stall_float", 32'(bus.float_o), 32'(held));
      check("stall_valid", 32'(bus.out_valid_o), 32'd1);
      check("stall_ready", 32'(bus.in_ready_o), 32'd0);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    check("post_valid", 32'(bus.out_valid_o), 32'd0);
    check("post_ready", 32'(bus.in_ready_o), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [IW-1:0] r;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.int_i       = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.in_ready_o), 32'd1);
    check("rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_float", 32'(bus.float_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    convert(16'd0, 0);
    convert(16'd1, 0);
    convert(16'hFFFF, 0);
    convert(16'h8000, 0);
    convert(16'd511, 0);
    convert(16'd385, 0);
    convert(16'd200, 5);
    convert(16'd3, 0);
    convert(16'd1000, 0);

    // Reset mid-normalisation, with a competing in_valid_i during reset.
    bus.in_valid_i = 1'b1;
    bus.int_i      = 16'd1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("norm_busy", 32'(bus.in_ready_o), 32'd0);
    rst            = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.int_i      = 16'd5;
    @(negedge clk);
    check("midrst_ready", 32'(bus.in_ready_o), 32'd1);
    check("midrst_valid", 32'(bus.out_valid_o), 32'd0);
    check("midrst_float", 32'(bus.float_o), 32'd0);
    rst            = 1'b0;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("after_rst_idle", 32'(bus.in_ready_o), 32'd1);
    check("after_rst_valid", 32'(bus.out_valid_o), 32'd0);

    for (int n = 0; n < 40; n++) begin
      r = IW'($urandom >> $urandom_range(0, 16));
      if ($urandom_range(0, 1) == 1) r = -r;
      convert(r, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/int_to_float_pipe.md
# int_to_float_pipe

Parametrised, handshaked signed-integer to floating-point converter. Accepts an INT_WIDTH-bit two's-complement integer and returns a sign/exponent/mantissa word using an iterative one-bit-per-cycle normaliser. It is the configurable, flow-controlled successor of the fixed 8-bit to 13-bit converter. It sits between integer datapaths and the floating-point arithmetic blocks.

## Interface
- INT_WIDTH, 16: input integer width; must be at least 2.
- MAN_WIDTH, 8: mantissa width; the leading one is explicit.
- EXP_WIDTH, 5: exponent width; must satisfy 2^EXP_WIDTH > INT_WIDTH+1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid_i  in  1  int_i is valid.
- in_ready_o  out  1  converter can accept an input.
- int_i  in  INT_WIDTH  signed integer.
- out_valid_o  out  1  float_o is valid.
- out_ready_i  in  1  consumer accepts float_o.
- float_o  out  1+EXP_WIDTH+MAN_WIDTH  {sign, exp, mant}. Value = 0.mant × 2^exp.

## Operation
- Format:
  - sign = int_i MSB.
  - mag = |int_i| as an unsigned INT_WIDTH-bit value. −2^(INT_WIDTH−1) maps to mag = 2^(INT_WIDTH−1); no overflow.
  - exp = index of the leading one of mag, plus 1.
  - mant = top MAN_WIDTH bits starting at the leading one. If INT_WIDTH < MAN_WIDTH, the remaining low bits are zero-padded.
- Zero input gives float_o = 0 (sign 0, exp 0, mant 0).
- States:
  - IDLE: in_ready_o=1. On in_valid_i, capture sign and mag, and set exp=INT_WIDTH. If mag==0, go to DONE with a zero result; otherwise go to NORM.
  - NORM: if mag MSB==1, form mant (rounding per Configuration), register float_o, and go to DONE. Otherwise mag<<=1, exp−=1, and stay in NORM.
  - DONE: out_valid_o=1. When out_ready_i=1, return to IDLE.
- int_i is sampled only on the accept edge. It may change afterwards.
- One conversion is in flight at a time. in_ready_o is 0 in NORM and DONE, and in_valid_i is ignored in those states.
- float_o and out_valid_o are registered. float_o is stable throughout DONE.

## Timing
- Reset values: in_ready_o=1 (IDLE), out_valid_o=0, float_o=0, internal mag/exp/sign=0.
- Let lz be the number of leading zeros of mag, and let input be accepted at edge N.
  - Nonzero input: out_valid_o rises after edge N+lz+1.
  - Zero input: out_valid_o rises after edge N.
- Output handshake completes on an edge where out_valid_o & out_ready_i. in_ready_o is 1 starting the next cycle; there is no same-cycle accept.
- Worst case (default params, int_i=1): lz=15, so out_valid_o rises after edge N+16.
- Throughput: lz+3 cycles per conversion (nonzero input) with out_ready_i held high.
- rst in any state takes priority:
  - next state IDLE, all outputs at reset values;
  - the in-flight conversion is discarded;
  - any simultaneous in_valid_i is ignored.
- Backpressure: DONE is held indefinitely while out_ready_i=0. float_o must not change.

## Configuration
- INT_TO_FLOAT_ROUND_EN defined: round-to-nearest-even on the bits below mant. These apply only when INT_WIDTH > MAN_WIDTH.
  - guard = first dropped bit; sticky = OR of the remaining dropped bits.
  - Increment mant if guard & (sticky | mant[0]).
  - On mantissa overflow (all ones +1): mant = 1 followed by zeros, exp+1. The maximum exp is INT_WIDTH+1.
  - Rounding is applied in the NORM→DONE cycle and adds no latency.
- Not defined: the dropped bits are truncated and exp never exceeds INT_WIDTH.

## Test plan
- All cases use default parameters.
- int_i=0 -> float_o=0, out_valid_o after edge N.
- int_i=1 -> sign 0, exp 1, mant 0x80; out_valid_o after edge N+16. int_i=−1 -> same with sign 1.
- int_i=0x8000 (−32768) -> sign 1, exp 16, mant 0x80; out_valid_o after edge N+1.
- int_i=511:
  - with INT_TO_FLOAT_ROUND_EN -> exp 10, mant 0x80;
  - without it -> exp 9, mant 0xFF.
- int_i=385 (tie, even lsb) -> exp 9, mant 0xC0 in both builds.
- Handshake and reset:
  - Hold out_ready_i=0 for 5 cycles in DONE -> float_o stable, in_ready_o=0, a new in_valid_i is not accepted.
  - Assert rst during NORM -> IDLE next cycle, out_valid_o=0, float_o=0.
  - Back-to-back inputs 3, 1000 -> two correct results in order.
